// File: rtl/dcpu16_mbus_arb.sv
`default_nettype none
// ============================================================================
// Module      : dcpu16_mbus_arb
// Description : Two-requester arbiter for the DCPU16 shared memory bus.
//               The instruction-fetch port (f_*) and the data port (g_*)
//               compete for a single memory bus (m_*). Ties are resolved
//               round-robin; a wait counter aborts any transaction that
//               has not completed within TMO bus-wait cycles.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               f_stb/f_adr     - fetch request and word address
//               f_ack/f_dti     - fetch completion pulse and fetched word
//               g_stb/g_wre/g_adr/g_dto - data request, write flag,
//                                 address and write data
//               g_ack/g_dti     - data completion pulse and read data
//               m_stb/m_wre/m_adr/m_dto - shared bus request
//               m_ack/m_dti     - shared bus completion and read data
//               tmo             - pulses with the ack of an aborted access
// Revision    : 1.0 - initial release
// ============================================================================
module dcpu16_mbus_arb #(
    parameter int TMO = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_stb,
    input  logic [15:0] f_adr,
    output logic        f_ack,
    output logic [15:0] f_dti,
    input  logic        g_stb,
    input  logic        g_wre,
    input  logic [15:0] g_adr,
    input  logic [15:0] g_dto,
    output logic        g_ack,
    output logic [15:0] g_dti,
    output logic        m_stb,
    output logic        m_wre,
    output logic [15:0] m_adr,
    output logic [15:0] m_dto,
    input  logic        m_ack,
    input  logic [15:0] m_dti,
    output logic        tmo
);

    localparam logic [7:0] c_tmo = TMO[7:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_last_g;   // 1: the data port received the most recent grant

    // A requester whose ack is high this cycle still holds its strobe for
    // that one cycle; masking it prevents granting the same request twice.
    logic       w_f_elig;
    logic       w_g_elig;
    logic       w_pick_f;
    logic       w_pick_g;
    logic [7:0] w_cnt_inc;
    logic [15:0] w_rdata;

    assign w_f_elig  = f_stb & ~f_ack;
    assign w_g_elig  = g_stb & ~g_ack;
    assign w_pick_f  = w_f_elig & (~w_g_elig | r_last_g);
    assign w_pick_g  = w_g_elig & ~w_pick_f;
    assign w_cnt_inc = r_cnt + 8'd1;
    // Aborted transactions return zero instead of whatever is on the bus.
    assign w_rdata   = m_ack ? m_dti : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_last_g <= 1'b1;
            m_stb    <= 1'b0;
            m_wre    <= 1'b0;
            m_adr    <= 16'h0000;
            m_dto    <= 16'h0000;
            f_ack    <= 1'b0;
            f_dti    <= 16'h0000;
            g_ack    <= 1'b0;
            g_dti    <= 16'h0000;
            tmo      <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            g_ack <= 1'b0;
            tmo   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // m_ack is deliberately ignored here.
                    if (w_pick_f) begin
                        r_state  <= FETCH;
                        r_last_g <= 1'b0;
                        r_cnt    <= 8'd0;
                        m_stb    <= 1'b1;
                        m_wre    <= 1'b0;
                        m_adr    <= f_adr;
                        m_dto    <= 16'h0000;
                    end else if (w_pick_g) begin
                        r_state  <= DATA;
                        r_last_g <= 1'b1;
                        r_cnt    <= 8'd0;
                        m_stb    <= 1'b1;
                        m_wre    <= g_wre;
                        m_adr    <= g_adr;
                        m_dto    <= g_dto;
                    end
                end
                FETCH, DATA: begin
                    // A completion arriving on the same cycle the counter
                    // would hit the limit wins over the abort.
                    if (m_ack || (w_cnt_inc == c_tmo)) begin
                        r_state <= IDLE;
                        m_stb   <= 1'b0;
                        m_wre   <= 1'b0;
                        tmo     <= ~m_ack;
                        if (r_state == FETCH) begin
                            f_ack <= 1'b1;
                            f_dti <= w_rdata;
                        end else begin
                            g_ack <= 1'b1;
                            g_dti <= w_rdata;
                        end
                    end
                    if (!m_ack) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    m_stb   <= 1'b0;
                    m_wre   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcpu16_mbus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcpu16_mbus_arb
// Description : Directed self-checking bench for dcpu16_mbus_arb (TMO=4).
//               Inputs change 1 time unit after each rising edge; outputs
//               are sampled at the same point, i.e. they show the register
//               values loaded by the edge just passed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcpu16_mbus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_stb;
    logic [15:0] f_adr;
    logic        f_ack;
    logic [15:0] f_dti;
    logic        g_stb;
    logic        g_wre;
    logic [15:0] g_adr;
    logic [15:0] g_dto;
    logic        g_ack;
    logic [15:0] g_dti;
    logic        m_stb;
    logic        m_wre;
    logic [15:0] m_adr;
    logic [15:0] m_dto;
    logic        m_ack;
    logic [15:0] m_dti;
    logic        tmo;

    int n_checks = 0;
    int n_errors = 0;

    dcpu16_mbus_arb #(.TMO(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .f_stb (f_stb),
        .f_adr (f_adr),
        .f_ack (f_ack),
        .f_dti (f_dti),
        .g_stb (g_stb),
        .g_wre (g_wre),
        .g_adr (g_adr),
        .g_dto (g_dto),
        .g_ack (g_ack),
        .g_dti (g_dti),
        .m_stb (m_stb),
        .m_wre (m_wre),
        .m_adr (m_adr),
        .m_dto (m_dto),
        .m_ack (m_ack),
        .m_dti (m_dti),
        .tmo   (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; f_stb = 1'b0; f_adr = 16'h0; g_stb = 1'b0; g_wre = 1'b0;
        g_adr = 16'h0; g_dto = 16'h0; m_ack = 1'b0; m_dti = 16'h0;
        #1;
        tick();
        tick();
        // ---- reset state ----
        chk("rst_m_stb", m_stb, 16'h0);
        chk("rst_m_wre", m_wre, 16'h0);
        chk("rst_m_adr", m_adr, 16'h0);
        chk("rst_m_dto", m_dto, 16'h0);
        chk("rst_f_ack", f_ack, 16'h0);
        chk("rst_g_ack", g_ack, 16'h0);
        chk("rst_f_dti", f_dti, 16'h0);
        chk("rst_g_dti", g_dti, 16'h0);
        chk("rst_tmo",   tmo,   16'h0);

        // ---- single fetch, m_ack on second m_stb cycle ----
        rst = 1'b0; f_stb = 1'b1; f_adr = 16'h0100;
        tick();
        chk("f1_m_stb", m_stb, 16'h1);
        chk("f1_m_adr", m_adr, 16'h0100);
        chk("f1_m_wre", m_wre, 16'h0);
        chk("f1_f_ack_early", f_ack, 16'h0);
        tick();
        chk("f1_m_stb2", m_stb, 16'h1);
        m_ack = 1'b1; m_dti = 16'h7C01;
        tick();
        chk("f1_f_ack", f_ack, 16'h1);
        chk("f1_f_dti", f_dti, 16'h7C01);
        chk("f1_g_ack", g_ack, 16'h0);
        chk("f1_m_stb_done", m_stb, 16'h0);
        chk("f1_tmo", tmo, 16'h0);
        f_stb = 1'b0; m_ack = 1'b0; m_dti = 16'h0;
        tick();
        chk("f1_f_ack_pulse", f_ack, 16'h0);
        chk("f1_f_dti_hold", f_dti, 16'h7C01);

        // ---- m_ack while idle is ignored ----
        m_ack = 1'b1; m_dti = 16'hDEAD;
        tick();
        chk("idle_f_ack", f_ack, 16'h0);
        chk("idle_g_ack", g_ack, 16'h0);
        chk("idle_m_stb", m_stb, 16'h0);
        m_ack = 1'b0; m_dti = 16'h0;

        // ---- data write; non-winner address change must not leak ----
        g_stb = 1'b1; g_wre = 1'b1; g_adr = 16'h8000; g_dto = 16'hBEEF;
        tick();
        chk("w_m_stb", m_stb, 16'h1);
        chk("w_m_wre", m_wre, 16'h1);
        chk("w_m_adr", m_adr, 16'h8000);
        chk("w_m_dto", m_dto, 16'hBEEF);
        f_adr = 16'h1234;
        tick();
        chk("w_m_adr_hold", m_adr, 16'h8000);
        chk("w_g_ack_early", g_ack, 16'h0);
        m_ack = 1'b1; m_dti = 16'h4321;
        tick();
        chk("w_g_ack", g_ack, 16'h1);
        chk("w_g_dti", g_dti, 16'h4321);
        chk("w_f_ack", f_ack, 16'h0);
        chk("w_m_wre_done", m_wre, 16'h0);
        g_stb = 1'b0; g_wre = 1'b0; m_ack = 1'b0; m_dti = 16'h0;
        tick();
        chk("w_g_ack_pulse", g_ack, 16'h0);

        // ---- round robin after reset: f, g, f ----
        rst = 1'b1;
        tick();
        rst = 1'b0; f_stb = 1'b1; g_stb = 1'b1; f_adr = 16'h0200; g_adr = 16'h0300;
        tick();
        chk("rr1_m_adr", m_adr, 16'h0200);
        m_ack = 1'b1; m_dti = 16'hAAAA;
        tick();
        chk("rr1_f_ack", f_ack, 16'h1);
        chk("rr1_g_ack", g_ack, 16'h0);
        chk("rr1_f_dti", f_dti, 16'hAAAA);
        m_ack = 1'b0;
        tick();
        chk("rr2_m_adr", m_adr, 16'h0300);
        chk("rr2_m_stb", m_stb, 16'h1);
        m_ack = 1'b1; m_dti = 16'h5555;
        tick();
        chk("rr2_g_ack", g_ack, 16'h1);
        chk("rr2_f_ack", f_ack, 16'h0);
        chk("rr2_g_dti", g_dti, 16'h5555);
        m_ack = 1'b0;
        tick();
        chk("rr3_m_adr", m_adr, 16'h0200);
        m_ack = 1'b1; m_dti = 16'h1111;
        tick();
        chk("rr3_f_ack", f_ack, 16'h1);
        chk("rr3_f_dti", f_dti, 16'h1111);
        f_stb = 1'b0; g_stb = 1'b0; m_ack = 1'b0; m_dti = 16'h0;
        tick();

        // ---- timeout with TMO=4 ----
        f_stb = 1'b1; f_adr = 16'h0400;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_m_stb_held", m_stb, 16'h1);
            chk("to_f_ack_held", f_ack, 16'h0);
        end
        tick();
        chk("to_m_stb", m_stb, 16'h0);
        chk("to_f_ack", f_ack, 16'h1);
        chk("to_f_dti", f_dti, 16'h0000);
        chk("to_tmo", tmo, 16'h1);
        f_stb = 1'b0;
        tick();
        chk("to_tmo_pulse", tmo, 16'h0);

        // ---- m_ack on the limit cycle counts as completion ----
        f_stb = 1'b1; f_adr = 16'h0500;
        tick();
        tick();
        tick();
        tick();
        chk("lim_m_stb", m_stb, 16'h1);
        m_ack = 1'b1; m_dti = 16'h6666;
        tick();
        chk("lim_f_ack", f_ack, 16'h1);
        chk("lim_f_dti", f_dti, 16'h6666);
        chk("lim_tmo", tmo, 16'h0);
        f_stb = 1'b0; m_ack = 1'b0; m_dti = 16'h0;
        tick();

        // ---- reset during a data transaction ----
        g_stb = 1'b1; g_wre = 1'b1; g_adr = 16'h9000; g_dto = 16'h1357;
        tick();
        chk("rd_m_stb", m_stb, 16'h1);
        rst = 1'b1; m_ack = 1'b1; m_dti = 16'hFFFF;
        tick();
        chk("rd_m_stb_rst", m_stb, 16'h0);
        chk("rd_g_ack", g_ack, 16'h0);
        chk("rd_m_wre", m_wre, 16'h0);
        chk("rd_g_dti", g_dti, 16'h0);
        rst = 1'b0; m_ack = 1'b0; m_dti = 16'h0; g_stb = 1'b0; g_wre = 1'b0;
        tick();
        chk("rd_g_ack_after", g_ack, 16'h0);

        // ---- reset during fetch restores fetch priority on a tie ----
        f_stb = 1'b1; f_adr = 16'h0600;
        tick();
        chk("rf_m_adr", m_adr, 16'h0600);
        rst = 1'b1;
        tick();
        chk("rf_m_stb", m_stb, 16'h0);
        chk("rf_f_ack", f_ack, 16'h0);
        rst = 1'b0; f_adr = 16'h0700; g_stb = 1'b1; g_adr = 16'h0800;
        tick();
        chk("rf_tie_m_adr", m_adr, 16'h0700);
        m_ack = 1'b1; m_dti = 16'h2468;
        tick();
        chk("rf_f_ack_done", f_ack, 16'h1);
        f_stb = 1'b0; g_stb = 1'b0; m_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
